// File: rtl/reg_mem_unit_pkg.sv
// reg_mem_unit_pkg: state encoding, width defaults and MMIO abort value shared by
// reg_mem_unit and its RAM.
package reg_mem_unit_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 13;
    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_VALID   = 2'd1;
    localparam logic [1:0] ST_MMIO_RD = 2'd2;
    localparam logic [1:0] ST_MMIO_WR = 2'd3;
    localparam logic [63:0] MMIO_ABORT = '1;
endpackage

// File: rtl/reg_mem_unit_ram.sv
// reg_mem_ram: single-port data memory; the parent's reg_m_out register is the
// read register, so together they form a synchronous-read block RAM.
module reg_mem_ram
    import reg_mem_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    assign rdata = mem[addr];
endmodule

// File: rtl/reg_mem_unit.sv
// reg_mem_unit: A/D registers plus data memory M[A]; addresses beyond RAM depth go
// to a req/ack MMIO bus with timeout, and m_valid stalls the CPU until M is current.
module reg_mem_unit
    import reg_mem_unit_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int MMIO_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_a_en,
    input  logic              reg_d_en,
    input  logic              reg_m_en,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] reg_a_out,
    output logic [DATA_W-1:0] reg_d_out,
    output logic [DATA_W-1:0] reg_m_out,
    output logic              m_valid,
    output logic [DATA_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wdata,
    output logic              mmio_we,
    output logic              mmio_re,
    input  logic [DATA_W-1:0] mmio_rdata,
    input  logic              mmio_ack,
    output logic              mmio_err
);
    localparam int CW = $clog2(MMIO_TIMEOUT + 1);

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] ram_rdata;
    logic              a_mmio, ram_we, timeout;

    function automatic logic is_mmio(input logic [DATA_W-1:0] x);
        return |x[DATA_W-1:ADDR_W];
    endfunction

    assign a_mmio    = is_mmio(reg_a_out);
    assign ram_we    = state == ST_VALID && reg_m_en && !a_mmio;
    assign timeout   = cnt == CW'(MMIO_TIMEOUT - 1);
    assign mmio_addr = reg_a_out;

    reg_mem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (reg_a_out[ADDR_W-1:0]),
        .wdata(data_in),
        .rdata(ram_rdata)
    );

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state      <= ST_FETCH;
            cnt        <= '0;
            reg_a_out  <= '0;
            reg_d_out  <= '0;
            reg_m_out  <= '0;
            m_valid    <= 1'b0;
            mmio_wdata <= '0;
            mmio_we    <= 1'b0;
            mmio_re    <= 1'b0;
            mmio_err   <= 1'b0;
        end else begin
            if (reg_d_en) reg_d_out <= data_in;
            case (state)
                ST_FETCH: begin
                    reg_m_out <= ram_rdata;
                    m_valid   <= 1'b1;
                    state     <= ST_VALID;
                end
                ST_VALID:
                    if (reg_m_en && a_mmio) begin
                        // an MMIO write beats a simultaneous A load; upstream re-issues it
                        mmio_wdata <= data_in;
                        mmio_we    <= 1'b1;
                        m_valid    <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_MMIO_WR;
                    end else if (reg_a_en) begin
                        reg_a_out <= data_in;
                        m_valid   <= 1'b0;
                        cnt       <= '0;
                        mmio_re   <= is_mmio(data_in);
                        state     <= is_mmio(data_in) ? ST_MMIO_RD : ST_FETCH;
                    end else if (reg_m_en)
                        reg_m_out <= data_in;
                ST_MMIO_RD:
                    if (mmio_ack || timeout) begin
                        reg_m_out <= mmio_ack ? mmio_rdata : MMIO_ABORT[DATA_W-1:0];
                        mmio_err  <= mmio_err | !mmio_ack;
                        mmio_re   <= 1'b0;
                        m_valid   <= 1'b1;
                        state     <= ST_VALID;
                    end else
                        cnt <= cnt + 1'b1;
                default:
                    if (mmio_ack || timeout) begin
                        reg_m_out <= mmio_wdata;
                        mmio_err  <= mmio_err | !mmio_ack;
                        mmio_we   <= 1'b0;
                        m_valid   <= 1'b1;
                        state     <= ST_VALID;
                    end else
                        cnt <= cnt + 1'b1;
            endcase
        end
endmodule

// File: tb/tb_reg_mem_unit.sv
// tb_reg_mem_unit: directed stimulus with a scoreboard queue of expected M values,
// popped by a monitor on every rising edge of m_valid.
module tb_reg_mem_unit;
    logic        clk = 0, rst = 1;
    logic        reg_a_en = 0, reg_d_en = 0, reg_m_en = 0;
    logic [15:0] data_in = 0, mmio_rdata = 0;
    logic        mmio_ack = 0;
    logic [15:0] reg_a_out, reg_d_out, reg_m_out, mmio_addr, mmio_wdata;
    logic        m_valid, mmio_we, mmio_re, mmio_err;

    typedef struct {logic [15:0] m; logic err; bit dc;} exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0;
    logic prev_v = 0;

    reg_mem_unit #(.DATA_W(16), .ADDR_W(13), .MMIO_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .reg_a_en(reg_a_en), .reg_d_en(reg_d_en), .reg_m_en(reg_m_en),
        .data_in(data_in), .reg_a_out(reg_a_out), .reg_d_out(reg_d_out), .reg_m_out(reg_m_out),
        .m_valid(m_valid), .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_we(mmio_we),
        .mmio_re(mmio_re), .mmio_rdata(mmio_rdata), .mmio_ack(mmio_ack), .mmio_err(mmio_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] m, input logic err, input bit dc);
        q.push_back('{m: m, err: err, dc: dc});
    endtask

    always @(posedge clk) begin
        #1;
        if (m_valid && !prev_v) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got m=%h with empty scoreboard", reg_m_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (!e.dc) chk("sb_m_out", reg_m_out, e.m);
                chk("sb_mmio_err", {15'd0, mmio_err}, {15'd0, e.err});
            end
        end
        prev_v = m_valid;
    end

    task automatic op(input logic a, input logic d, input logic m, input logic [15:0] v);
        @(negedge clk);
        reg_a_en = a; reg_d_en = d; reg_m_en = m; data_in = v;
        @(negedge clk);
        reg_a_en = 0; reg_d_en = 0; reg_m_en = 0;
    endtask

    task automatic wait_valid(input int exp_stall);
        int n = 0;
        while (!m_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!m_valid) chk("valid_timeout", 16'd0, 16'd1);
        else if (exp_stall >= 0) chk("stall_cycles", 16'(n), 16'(exp_stall));
    endtask

    // Peripheral model: acks on the lat-th strobe cycle (never if lat==0).
    task automatic serve(input int lat, input logic [15:0] rd, output int hi);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            if (mmio_re || mmio_we) begin
                hi++;
                mmio_ack   = (hi == lat);
                mmio_rdata = rd;
            end else begin
                mmio_ack = 0;
                if (hi > 0) break;
            end
            @(negedge clk);
        end
        mmio_ack = 0;
    endtask

    initial begin
        int hi;
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        // reset and initial fetch of unknown mem[0]
        push(16'h0, 1'b0, 1'b1);
        @(negedge clk); @(negedge clk);
        rst = 0;
        wait_valid(-1);
        op(0, 1, 0, 16'h5555);
        chk("d_load", reg_d_out, 16'h5555);
        op(0, 0, 1, 16'h1234);
        chk("fwd_1234", reg_m_out, 16'h1234);
        chk("fwd_valid", {15'd0, m_valid}, 16'd1);
        // reset mid-run
        @(negedge clk);
        rst = 1;
        #1;
        chk("rst_a", reg_a_out, 16'h0);
        chk("rst_d", reg_d_out, 16'h0);
        chk("rst_m", reg_m_out, 16'h0);
        chk("rst_valid", {15'd0, m_valid}, 16'd0);
        chk("rst_strobes", {14'd0, mmio_re, mmio_we}, 16'd0);
        chk("rst_wdata", mmio_wdata, 16'h0);
        @(negedge clk);
        push(16'h1234, 1'b0, 1'b0);
        rst = 0;
        @(negedge clk); @(negedge clk);
        chk("post_rst_valid", {15'd0, m_valid}, 16'd1);
        // write forwarding at A=5
        push(16'h0, 1'b0, 1'b1);
        op(1, 0, 0, 16'h0005);
        wait_valid(1);
        op(0, 0, 1, 16'hBEEF);
        chk("fwd_beef", reg_m_out, 16'hBEEF);
        push(16'hBEEF, 1'b0, 1'b0);
        op(1, 0, 0, 16'h0005);
        wait_valid(1);
        // simultaneous a_en+m_en writes old A
        push(16'h0, 1'b0, 1'b1);
        op(1, 0, 0, 16'h0007);
        wait_valid(1);
        op(0, 0, 1, 16'h7777);
        push(16'h0, 1'b0, 1'b1);
        op(1, 0, 0, 16'h0003);
        wait_valid(1);
        push(16'h7777, 1'b0, 1'b0);
        op(1, 0, 1, 16'h0007);
        chk("am_new_a", reg_a_out, 16'h0007);
        wait_valid(1);
        push(16'h0007, 1'b0, 1'b0);
        op(1, 0, 0, 16'h0003);
        wait_valid(1);
        // MMIO read, ack on third strobe cycle
        push(16'h00A5, 1'b0, 1'b0);
        op(1, 0, 0, 16'h2000);
        chk("rd_re", {15'd0, mmio_re}, 16'd1);
        chk("rd_addr", mmio_addr, 16'h2000);
        serve(3, 16'h00A5, hi);
        chk("rd_re_cycles", 16'(hi), 16'd3);
        chk("rd_err", {15'd0, mmio_err}, 16'd0);
        // MMIO write with timeout
        push(16'h1111, 1'b0, 1'b0);
        op(1, 0, 0, 16'h3000);
        serve(1, 16'h1111, hi);
        push(16'h0042, 1'b1, 1'b0);
        op(0, 0, 1, 16'h0042);
        chk("wr_we", {15'd0, mmio_we}, 16'd1);
        chk("wr_wdata", mmio_wdata, 16'h0042);
        chk("wr_addr", mmio_addr, 16'h3000);
        serve(0, 16'h0, hi);
        chk("wr_we_cycles", 16'(hi), 16'd15);
        chk("wr_valid", {15'd0, m_valid}, 16'd1);
        push(16'h1234, 1'b1, 1'b0);
        op(1, 0, 0, 16'h0000);
        wait_valid(1);
        chk("err_sticky", {15'd0, mmio_err}, 16'd1);
        // reset during MMIO read, then late ack ignored
        op(1, 0, 0, 16'h2000);
        chk("rd2_re", {15'd0, mmio_re}, 16'd1);
        rst = 1;
        #1;
        chk("rst_rd_re", {15'd0, mmio_re}, 16'd0);
        chk("rst_rd_err", {15'd0, mmio_err}, 16'd0);
        chk("rst_rd_a", reg_a_out, 16'h0);
        @(negedge clk);
        push(16'h1234, 1'b0, 1'b0);
        rst = 0;
        mmio_ack = 1;
        mmio_rdata = 16'hDEAD;
        @(negedge clk);
        mmio_ack = 0;
        chk("late_ack_valid", {15'd0, m_valid}, 16'd1);
        chk("late_ack_re", {15'd0, mmio_re}, 16'd0);
        // ack on the final timeout cycle wins
        push(16'hCAFE, 1'b0, 1'b0);
        op(1, 0, 0, 16'h2000);
        serve(15, 16'hCAFE, hi);
        chk("edge_ack_cycles", 16'(hi), 16'd15);
        chk("edge_ack_err", {15'd0, mmio_err}, 16'd0);
        @(negedge clk);
        chk("sb_drained", 16'(q.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_mem_unit.md
Name: reg_mem_unit

Overview:
Parametrised successor to the CPU-side A/D/M storage block. Holds the A and D registers and a block-RAM data memory with synchronous, registered read. Routes addresses beyond RAM depth to an external memory-mapped I/O bus with a req/ack handshake and a timeout. Exports a valid/busy indication so the CPU stalls while M is not yet current.

Parameters:
DATA_W, 16, width of A, D, M and data_in
ADDR_W, 13, RAM address bits; DEPTH = 2**ADDR_W words; DATA_W > ADDR_W required
MMIO_TIMEOUT, 15, max cycles waiting for mmio_ack before abort (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
reg_a_en  input  1  load A from data_in
reg_d_en  input  1  load D from data_in
reg_m_en  input  1  write data_in to M[A]
data_in  input  DATA_W  write data for A/D/M
reg_a_out  output  DATA_W  A register
reg_d_out  output  DATA_W  D register
reg_m_out  output  DATA_W  registered value of M[A]; meaningful only when m_valid=1
m_valid  output  1  reg_m_out matches current A; CPU stalls when 0
mmio_addr  output  DATA_W  equals A whenever a strobe is high
mmio_wdata  output  DATA_W  write data, held with mmio_we
mmio_we  output  1  MMIO write strobe, held until ack or timeout
mmio_re  output  1  MMIO read strobe, held until ack or timeout
mmio_rdata  input  DATA_W  read data, sampled when mmio_ack=1
mmio_ack  input  1  one-cycle completion from peripheral
mmio_err  output  1  sticky; set on any MMIO timeout

Behaviour:
- Reset (async, any time, including mid-MMIO): A=0, D=0, reg_m_out=0, m_valid=0, mmio_re=mmio_we=0, mmio_wdata=0, mmio_err=0, timeout counter=0, state=FETCH. RAM contents are not reset and are preserved.
- Region: A < DEPTH is RAM, indexed by A[ADDR_W-1:0]. A >= DEPTH is MMIO.
- D: loads on any edge with reg_d_en=1, regardless of state.
- States:
  - FETCH: RAM read of M[A] issued. Next edge: reg_m_out<=mem[A], m_valid<=1, go VALID.
  - VALID (m_valid=1): accepts reg_a_en and reg_m_en; see rules below.
  - MMIO_RD: mmio_re=1, m_valid=0. On mmio_ack: reg_m_out<=mmio_rdata, go VALID. On timeout: reg_m_out<=all-ones, mmio_err<=1, go VALID.
  - MMIO_WR: mmio_we=1, m_valid=0. On ack or timeout: reg_m_out<=mmio_wdata, go VALID; timeout also sets mmio_err.
- Rules in VALID:
  - m_en only, RAM: mem[A]<=data_in and reg_m_out<=data_in on the same edge (write forwarding, no bubble). Stay VALID.
  - m_en only, MMIO: latch mmio_wdata<=data_in, go MMIO_WR.
  - a_en only: A<=data_in, m_valid<=0. Go FETCH if the new address is RAM, else MMIO_RD.
  - a_en and m_en together: the M write uses the OLD A.
    - Old A is RAM: write completes and A updates on the same edge, then FETCH or MMIO_RD per the new A.
    - Old A is MMIO: the write wins, a_en is dropped, go MMIO_WR. Upstream re-issues a_en once m_valid=1.
- In FETCH, MMIO_RD and MMIO_WR, reg_a_en and reg_m_en are ignored; the CPU is stalled by m_valid=0.
- Timeout: counter clears on entry to an MMIO state and increments each cycle without ack. When it reaches MMIO_TIMEOUT cycles, the access aborts. An ack on that same cycle takes priority: no abort, no error.
- Ack arriving while no strobe is high is ignored.
- Latency: RAM read 1 cycle after an A change. MMIO access takes ack latency + 1 cycle.
- All outputs are registered. The RAM is inferred as block RAM with a synchronous read port.

Decomposition:
- Shared package: state encoding (FETCH, VALID, MMIO_RD, MMIO_WR), DATA_W/ADDR_W defaults, and the MMIO all-ones abort value.
- One sub-module: reg_mem_ram, a single-port block RAM with synchronous read, parametrised DATA_W/ADDR_W. Read data is registered in the parent.
- The FSM, A/D registers and timeout counter stay in the top level.

Test Plan:
- Assert rst mid-run after writing mem[0]=0x1234 -> all outputs 0. Two cycles after release, m_valid=1 and reg_m_out=0x1234.
- a_en data_in=0x0005, then m_en data_in=0xBEEF -> m_valid low for 1 cycle. reg_m_out=0xBEEF on the write edge. Reload A=5 -> reg_m_out=0xBEEF.
- With A=0x0003, assert a_en data_in=0x0007 and m_en together -> mem[3] written. A=7 afterwards and FETCH returns the old mem[7].
- A=0x2000 (MMIO), ack after 3 cycles with rdata=0x00A5 -> mmio_re high 3 cycles, mmio_addr=0x2000, reg_m_out=0x00A5, mmio_err=0.
- MMIO write of 0x0042 to 0x3000, ack never arrives -> mmio_we high exactly 15 cycles, then mmio_err=1 (sticky), m_valid=1, reg_m_out=0x0042.
- Assert rst during MMIO_RD -> mmio_re drops immediately, state FETCH. A late ack after release is ignored.
